// File: rtl/reg_scoreboard.sv
// Register scoreboard: a pending-write counter per architectural register.
// Decode stalls on RAW hazards or a saturated destination; write-back retires.
module reg_scoreboard #(
  parameter int NREG     = 32,
  parameter int PEND_MAX = 3,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(PEND_MAX + 1),
  localparam int IW      = $clog2(NREG * PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          reg1_read,
  input  logic [AW-1:0] reg1_addr,
  input  logic          reg2_read,
  input  logic [AW-1:0] reg2_addr,
  input  logic          wreg,
  input  logic [AW-1:0] wd,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic          flush,
  output logic          stall_o,
  output logic          issue_o,
  output logic [IW-1:0] inflight_o,
  output logic          err_o
);

  logic [CW-1:0] cnt [NREG];

  logic active;
  logic haz1, haz2, haz_full;
  logic do_inc, ret_ok, ret_err;

  // Hazards look only at registered counts, so a retire this cycle does not
  // release a stall until the next cycle. cnt[0] is held at zero.
  always_comb begin
    active   = id_valid & ~flush & ~rst;
    haz1     = reg1_read & (cnt[reg1_addr] != '0);
    haz2     = reg2_read & (cnt[reg2_addr] != '0);
    haz_full = wreg & (wd != '0) & (cnt[wd] == CW'(PEND_MAX));
    stall_o  = active & (haz1 | haz2 | haz_full);
    issue_o  = active & ~stall_o;
    do_inc   = issue_o & wreg & (wd != '0);
    ret_ok   = wb_we & (wb_waddr != '0) & (cnt[wb_waddr] != '0);
    ret_err  = wb_we & (wb_waddr != '0) & (cnt[wb_waddr] == '0) & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (do_inc && (wd == AW'(i)) && !(ret_ok && (wb_waddr == AW'(i))))
          cnt[i] <= cnt[i] + CW'(1);
        else if (ret_ok && (wb_waddr == AW'(i)) && !(do_inc && (wd == AW'(i))))
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Running total moves by the net of one possible issue and one valid retire.
  always_ff @(posedge clk) begin
    if (rst || flush)
      inflight_o <= '0;
    else if (do_inc && !ret_ok)
      inflight_o <= inflight_o + IW'(1);
    else if (ret_ok && !do_inc)
      inflight_o <= inflight_o - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_o <= 1'b0;
    else if (ret_err)
      err_o <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: each stimulus cycle queues its
// hand-computed outputs, and a negedge monitor pops and compares them.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic       reg1_read;
  logic [4:0] reg1_addr;
  logic       reg2_read;
  logic [4:0] reg2_addr;
  logic       wreg;
  logic [4:0] wd;
  logic       wb_we;
  logic [4:0] wb_waddr;
  logic       flush;
  logic       stall_o;
  logic       issue_o;
  logic [6:0] inflight_o;
  logic       err_o;

  typedef struct packed {
    logic [7:0] step;
    logic       stall;
    logic       issue;
    logic [6:0] inflight;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  reg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .reg1_read  (reg1_read),
    .reg1_addr  (reg1_addr),
    .reg2_read  (reg2_read),
    .reg2_addr  (reg2_addr),
    .wreg       (wreg),
    .wd         (wd),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .flush      (flush),
    .stall_o    (stall_o),
    .issue_o    (issue_o),
    .inflight_o (inflight_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int step,
                             input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  // One cycle of stimulus; inflight/err expectations are the registered
  // values before this cycle's edge, stall/issue are combinational.
  task automatic applyStimulus(
    input logic r, input logic iv,
    input logic r1r, input logic [4:0] r1a,
    input logic r2r, input logic [4:0] r2a,
    input logic wr, input logic [4:0] wdv,
    input logic we, input logic [4:0] wa,
    input logic fl,
    input logic es, input logic ei, input logic [6:0] einf, input logic ee);
    exp_t e;
    rst = r; id_valid = iv;
    reg1_read = r1r; reg1_addr = r1a;
    reg2_read = r2r; reg2_addr = r2a;
    wreg = wr; wd = wdv;
    wb_we = we; wb_waddr = wa;
    flush = fl;
    step_no++;
    e.step = 8'(step_no);
    e.stall = es; e.issue = ei; e.inflight = einf; e.err = ee;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("stall_o",    int'(e.step), {6'd0, stall_o}, {6'd0, e.stall});
      checkOutput("issue_o",    int'(e.step), {6'd0, issue_o}, {6'd0, e.issue});
      checkOutput("inflight_o", int'(e.step), inflight_o,      e.inflight);
      checkOutput("err_o",      int'(e.step), {6'd0, err_o},   {6'd0, e.err});
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; reg1_read = 1'b0; reg1_addr = '0;
    reg2_read = 1'b0; reg2_addr = '0; wreg = 1'b0; wd = '0;
    wb_we = 1'b0; wb_waddr = '0; flush = 1'b0;
    @(posedge clk);
    #1;
    //            rst iv r1r r1a r2r r2a wr wd we wa fl   stall issue infl err
    applyStimulus(1, 1, 1, 5'd3, 0, 0, 1, 5'd3, 0, 0, 0,   0, 0, 7'd0, 0);
    // RAW on r5, released the cycle after its retire
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd5, 0, 0,    0,   0, 1, 7'd0, 0);
    applyStimulus(0, 1, 1, 5'd5, 0, 0, 0, 0,    0, 0,    0,   1, 0, 7'd1, 0);
    applyStimulus(0, 1, 1, 5'd5, 0, 0, 0, 0,    1, 5'd5, 0,   1, 0, 7'd1, 0);
    applyStimulus(0, 1, 1, 5'd5, 0, 0, 0, 0,    0, 0,    0,   0, 1, 7'd0, 0);
    // Saturate r7 at three pending writes
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd7, 0, 0,    0,   0, 1, 7'd0, 0);
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd7, 0, 0,    0,   0, 1, 7'd1, 0);
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd7, 0, 0,    0,   0, 1, 7'd2, 0);
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd7, 0, 0,    0,   1, 0, 7'd3, 0);
    applyStimulus(0, 1, 0, 0,    1, 5'd7, 0, 0, 0, 0,    0,   1, 0, 7'd3, 0);
    // Simultaneous issue and retire on r9 leaves its count at 1
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd9, 0, 0,    0,   0, 1, 7'd3, 0);
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd9, 1, 5'd9, 0,   0, 1, 7'd4, 0);
    applyStimulus(0, 1, 1, 5'd9, 0, 0, 0, 0,    0, 0,    0,   1, 0, 7'd4, 0);
    // Retire of idle r12 sets the sticky error
    applyStimulus(0, 0, 0, 0,    0, 0, 0, 0,    1, 5'd12, 0,  0, 0, 7'd4, 0);
    applyStimulus(0, 0, 0, 0,    0, 0, 0, 0,    0, 0,    0,   0, 0, 7'd4, 1);
    // Flush clears all pending state but keeps err_o
    applyStimulus(0, 1, 1, 5'd9, 0, 0, 1, 5'd3, 0, 0,    1,   0, 0, 7'd4, 1);
    applyStimulus(0, 1, 1, 5'd9, 0, 0, 1, 5'd7, 0, 0,    0,   0, 1, 7'd0, 1);
    // Register 0 is never pending
    applyStimulus(0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0,   0, 1, 7'd1, 1);
    applyStimulus(0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0,   0, 1, 7'd1, 1);
    applyStimulus(0, 1, 1, 5'd0, 0, 0, 1, 5'd0, 1, 5'd0, 0,   0, 1, 7'd1, 1);
    // Issue to r11 with a retire of r7: net zero on the total
    applyStimulus(0, 1, 0, 0,    0, 0, 1, 5'd11, 1, 5'd7, 0,  0, 1, 7'd1, 1);
    // Reset mid-operation discards r11 and clears err_o
    applyStimulus(1, 1, 1, 5'd11, 0, 0, 0, 0,   0, 0,    0,   0, 0, 7'd1, 1);
    applyStimulus(0, 1, 1, 5'd11, 0, 0, 0, 0,   0, 0,    0,   0, 1, 7'd0, 0);
    applyStimulus(0, 0, 0, 0,    0, 0, 0, 0,    1, 5'd12, 0,  0, 0, 7'd0, 0);
    applyStimulus(0, 0, 0, 0,    0, 0, 0, 0,    0, 0,    0,   0, 0, 7'd0, 1);
    @(posedge clk);
    #1;
    checkOutput("queue_drained", 0, 7'(exp_q.size()), 7'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL provide parameter NREG, default 32, number of architectural registers (address width 5).
REQ-002 SHALL provide parameter PEND_MAX, default 3, maximum in-flight writes tracked per register (counter width 2).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_valid  input  1  decode stage holds a valid instruction this cycle.
REQ-006 reg1_read  input  1  instruction reads source port 1.
REQ-007 reg1_addr  input  5  source register address, port 1.
REQ-008 reg2_read  input  1  instruction reads source port 2.
REQ-009 reg2_addr  input  5  source register address, port 2.
REQ-010 wreg  input  1  instruction writes a destination register.
REQ-011 wd  input  5  destination register address.
REQ-012 wb_we  input  1  write-back stage retires a register write this cycle.
REQ-013 wb_waddr  input  5  address retired by write-back.
REQ-014 flush  input  1  discard all in-flight instructions.
REQ-015 stall_o  output  1  decode must hold; instruction not issued.
REQ-016 issue_o  output  1  instruction accepted into pipeline this cycle.
REQ-017 inflight_o  output  7  total pending writes across all registers.
REQ-018 err_o  output  1  sticky flag: retire seen for register with zero pending count.

Function
REQ-019 SHALL keep one 2-bit pending counter per register 1..31; register 0 SHALL never be pending and writes/retires to it SHALL be ignored.
REQ-020 SHALL assert stall_o combinationally when id_valid=1, flush=0, rst=0 and any of: reg1_read=1 and cnt[reg1_addr]!=0; reg2_read=1 and cnt[reg2_addr]!=0; wreg=1, wd!=0 and cnt[wd]==PEND_MAX.
REQ-021 Hazard check SHALL use registered counter values only; a same-cycle retire SHALL NOT clear a stall (no bypass), the stall releasing the following cycle.
REQ-022 issue_o SHALL equal id_valid & ~stall_o & ~flush & ~rst.
REQ-023 On issue with wreg=1 and wd!=0, cnt[wd] SHALL increment at the next edge.
REQ-024 On wb_we=1, wb_waddr!=0 and cnt[wb_waddr]!=0, that counter SHALL decrement at the next edge.
REQ-025 Issue and retire to the same register in one cycle SHALL leave its counter unchanged.
REQ-026 Retire to a register with count 0 SHALL leave state unchanged and set err_o, which stays 1 until rst.
REQ-027 inflight_o SHALL be a registered sum tracking every counter change (+1 issue, -1 valid retire, net 0 when both), never underflowing.
REQ-028 flush SHALL take priority over issue and retire: all counters and inflight_o cleared at next edge, stall_o=0 and issue_o=0 that cycle; err_o unaffected.
REQ-029 No counter SHALL exceed PEND_MAX or wrap.

Reset
REQ-030 With rst=1 at a clock edge, all counters, inflight_o and err_o SHALL be 0 after that edge.
REQ-031 While rst=1, stall_o and issue_o SHALL be 0 regardless of other inputs; reset mid-operation discards all pending state.

Verification
REQ-032 Issue wreg=1 wd=5 then next cycle reg1_read=1 reg1_addr=5 -> stall_o=1, issue_o=0; wb_we=1 wb_waddr=5 -> stall_o=0 one cycle after retire, inflight_o 1->0.
REQ-033 Three issues wd=7 with no retire, fourth wreg=1 wd=7 -> stall_o=1, cnt[7]=3, inflight_o=3.
REQ-034 Same cycle issue wd=9 and retire wb_waddr=9 with cnt[9]=1 -> cnt[9] stays 1, inflight_o unchanged.
REQ-035 wb_we=1 wb_waddr=12 with cnt[12]=0 -> err_o=1 next cycle, inflight_o unchanged; remains 1 until rst.
REQ-036 inflight_o=4, flush=1 with id_valid=1 -> issue_o=0, next cycle inflight_o=0 and reg1 read of previously pending register not stalled.
REQ-037 wreg=1 wd=0 repeatedly and reg1_addr=0 reads -> never stall, inflight_o stays 0.
